axis_pattern_source: RTL

//  Programmable AXI4S stimulus source: emits COUNT beats of a deterministic pattern (incrementing counter or Galois LFSR) on an AXI4S.Master port.

---
 rtl/axis_gen_pkg.sv | 39 +++
 rtl/axis_pattern_gen.sv | 59 +++++
 rtl/axis_pattern_source.sv | 139 +++++++++++++
 3 files changed

// File: rtl/axis_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axis_gen_pkg
//  Description : Shared types, constants and the LFSR step function for the
//                AXI4-Stream pattern source.
//  Contents    : state_t      - run-control FSM states
//                mode_t       - pattern selector (counter / Galois LFSR)
//                DEFAULT_POLY - x^32+x^22+x^2+x+1 feedback mask
//                lfsr_next()  - one Galois LFSR step (data widths up to 64)
//  Revision    : 1.0 - initial release
// ============================================================================
package axis_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        MODE_CNT  = 1'b0,
        MODE_LFSR = 1'b1
    } mode_t;

    localparam logic [31:0] DEFAULT_POLY = 32'h8020_0003;

    // Widest pattern supported by lfsr_next; narrower callers zero-extend.
    localparam int LFSR_MAX_W = 64;

    // Galois right-shift step: feedback applied when the bit shifted out is 1.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
        input logic [LFSR_MAX_W-1:0] x,
        input logic [LFSR_MAX_W-1:0] poly
    );
        return (x >> 1) ^ (x[0] ? poly : {LFSR_MAX_W{1'b0}});
    endfunction

endpackage
`default_nettype wire

// File: rtl/axis_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module      : axis_pattern_gen
//  Description : Pattern register for the stream source. Loads a seed and
//                steps either as a wrapping counter or a Galois LFSR.
//  Ports       : clk       - clock
//                resetn    - asynchronous active-low reset
//                i_load    - load seed and mode (takes priority over advance)
//                i_seed    - first pattern value
//                i_mode    - 0 = counter, 1 = LFSR
//                i_advance - step to the next pattern value
//                o_cur     - current pattern value
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_pattern_gen
    import axis_gen_pkg::*;
#(
    parameter int          DATA_W    = 32,
    parameter logic [31:0] LFSR_POLY = DEFAULT_POLY
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_seed,
    input  logic              i_mode,
    input  logic              i_advance,
    output logic [DATA_W-1:0] o_cur
);

    // Feedback mask trimmed (or zero-extended) to the pattern width.
    localparam logic [DATA_W-1:0] c_POLY = DATA_W'(LFSR_POLY);
    localparam logic [DATA_W-1:0] c_ONE  = {{(DATA_W-1){1'b0}}, 1'b1};

    mode_t             r_mode;
    logic [DATA_W-1:0] r_cur;
    logic [DATA_W-1:0] w_lfsr;
    logic [DATA_W-1:0] w_load_val;

    assign w_lfsr = DATA_W'(lfsr_next(LFSR_MAX_W'(r_cur), LFSR_MAX_W'(c_POLY)));

    // An all-zero LFSR state never leaves zero, so a zero seed starts at 1.
    assign w_load_val = (i_mode && (i_seed == {DATA_W{1'b0}})) ? c_ONE : i_seed;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_mode <= MODE_CNT;
            r_cur  <= {DATA_W{1'b0}};
        end else if (i_load) begin
            r_mode <= mode_t'(i_mode);
            r_cur  <= w_load_val;
        end else if (i_advance) begin
            r_cur  <= (r_mode == MODE_LFSR) ? w_lfsr : (r_cur + c_ONE);
        end
    end

    assign o_cur = r_cur;

endmodule
`default_nettype wire

// File: rtl/axis_pattern_source.sv
`default_nettype none
// ============================================================================
//  Module      : axis_pattern_source
//  Description : Programmable AXI4-Stream stimulus source. Emits COUNT beats
//                of a counter or LFSR pattern, honours backpressure, and can
//                invert bit 0 of one selected beat.
//  Ports       : clk, resetn           - clock, async active-low reset
//                start                 - run request, sampled only in IDLE
//                mode/seed/count       - run configuration, latched on start
//                inject_en/inject_idx  - beat corruption, latched on start
//                busy/done/beats_sent  - run status
//                out_valid/out_data    - AXI4-Stream master outputs
//                out_ready             - AXI4-Stream master input
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_pattern_source
    import axis_gen_pkg::*;
#(
    parameter int          DATA_W    = 32,
    parameter logic [31:0] LFSR_POLY = DEFAULT_POLY
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              mode,
    input  logic [DATA_W-1:0] seed,
    input  logic [31:0]       count,
    input  logic              inject_en,
    input  logic [31:0]       inject_idx,
    output logic              busy,
    output logic              done,
    output logic [31:0]       beats_sent,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready
);

    state_t            r_state;
    logic              r_valid;
    logic              r_busy;
    logic              r_done;
    logic [31:0]       r_beats;
    logic [31:0]       r_count;
    logic              r_inj_en;
    logic [31:0]       r_inj_idx;

    logic              w_accept;
    logic              w_xfer;
    logic              w_last;
    logic              w_advance;
    logic              w_inject;
    logic [DATA_W-1:0] w_cur;

    assign w_accept  = (r_state == IDLE) && start;
    assign w_xfer    = r_valid && out_ready;
    assign w_last    = ((r_beats + 32'd1) == r_count);
    // The pattern only moves after a completed transfer, so data is held
    // stable for as long as the sink stalls.
    assign w_advance = (r_state == RUN) && w_xfer && !w_last;

    // r_beats is the index of the beat currently on the bus.
    assign w_inject  = r_valid && r_inj_en && (r_beats == r_inj_idx);

    axis_pattern_gen #(
        .DATA_W    (DATA_W),
        .LFSR_POLY (LFSR_POLY)
    ) u_gen (
        .clk       (clk),
        .resetn    (resetn),
        .i_load    (w_accept),
        .i_seed    (seed),
        .i_mode    (mode),
        .i_advance (w_advance),
        .o_cur     (w_cur)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= IDLE;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_beats   <= 32'd0;
            r_count   <= 32'd0;
            r_inj_en  <= 1'b0;
            r_inj_idx <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_count   <= count;
                        r_inj_en  <= inject_en;
                        r_inj_idx <= inject_idx;
                        r_beats   <= 32'd0;
                        r_busy    <= 1'b1;
                        // An empty run spends one busy cycle in RUN with
                        // valid low, then finishes; valid is never raised.
                        r_valid   <= (count != 32'd0);
                        r_state   <= RUN;
                    end
                end
                RUN: begin
                    if (!r_valid) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else if (w_xfer) begin
                        r_beats <= r_beats + 32'd1;
                        if (w_last) begin
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign beats_sent = r_beats;
    assign out_valid  = r_valid;
    assign out_data   = w_cur ^ {{(DATA_W-1){1'b0}}, w_inject};

endmodule
`default_nettype wire
